// File: rtl/bch15_7_encoder.sv
//------------------------------------------------------------------------------
// Module   : bch15_7_encoder
// Purpose  : Serial systematic BCH(15,7) t=2 encoder with error-mask injection.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bch15_7_encoder #(
    parameter logic [8:0] GEN_POLY = 9'h1D1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  data_in,
    input  logic [14:0] err_mask,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [14:0] codeword,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [2:0] C_LAST_SHIFT = 3'd6;

    state_t      r_state;
    logic [6:0]  r_msg_sr;
    logic [6:0]  r_data;
    logic [14:0] r_mask;
    logic [7:0]  r_lfsr;
    logic [2:0]  r_cnt;

    logic        w_fb;
    logic [7:0]  w_lfsr_next;
    logic [14:0] w_cw_next;

    assign w_fb        = r_msg_sr[0] ^ r_lfsr[7];
    assign w_lfsr_next = {r_lfsr[6:0], 1'b0} ^ (w_fb ? GEN_POLY[7:0] : 8'h00);

    // Parity is bit-reversed into [14:7] so codeword[i] carries x^(14-i).
    always_comb begin
        w_cw_next      = 15'h0000;
        w_cw_next[6:0] = r_data;
        for (int j = 0; j < 8; j++) begin
            w_cw_next[7+j] = w_lfsr_next[7-j];
        end
        w_cw_next = w_cw_next ^ r_mask;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_msg_sr  <= 7'h00;
            r_data    <= 7'h00;
            r_mask    <= 15'h0000;
            r_lfsr    <= 8'h00;
            r_cnt     <= 3'd0;
            codeword  <= 15'h0000;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_msg_sr <= data_in;
                        r_data   <= data_in;
                        r_mask   <= err_mask;
                        r_lfsr   <= 8'h00;
                        r_cnt    <= 3'd0;
                        r_state  <= S_SHIFT;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    r_lfsr   <= w_lfsr_next;
                    r_msg_sr <= r_msg_sr >> 1;
                    r_cnt    <= r_cnt + 3'd1;
                    if (r_cnt == C_LAST_SHIFT) begin
                        codeword  <= w_cw_next;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bch15_7_encoder.sv
//------------------------------------------------------------------------------
// Module   : tb_bch15_7_encoder
// Purpose  : Directed self-checking bench for bch15_7_encoder.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_bch15_7_encoder;

    localparam logic [8:0] C_GEN = 9'h1D1;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  data_in;
    logic [14:0] err_mask;
    logic        out_valid;
    logic        out_ready;
    logic [14:0] codeword;
    logic        busy;

    int tests_run = 0;
    int tests_failed = 0;
    logic [14:0] exp_q[$];

    bch15_7_encoder #(.GEN_POLY(C_GEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .err_mask  (err_mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .codeword  (codeword),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Remainder of a codeword polynomial (codeword[i] = coeff of x^(14-i)) mod g(x).
    function automatic logic [7:0] rem_of(input logic [14:0] cw);
        logic [14:0] p;
        p = 15'h0000;
        for (int i = 0; i < 15; i++) p[14-i] = cw[i];
        for (int k = 14; k >= 8; k--)
            if (p[k]) p = p ^ (15'(C_GEN) << (k - 8));
        return p[7:0];
    endfunction

    // Reference encoder by polynomial long division of m(x)*x^8.
    function automatic logic [14:0] enc_model(input logic [6:0] d, input logic [14:0] m);
        logic [14:0] p;
        logic [14:0] cw;
        p = 15'h0000;
        for (int i = 0; i < 7; i++) p[14-i] = d[i];
        for (int k = 14; k >= 8; k--)
            if (p[k]) p = p ^ (15'(C_GEN) << (k - 8));
        cw = 15'h0000;
        for (int i = 0; i < 7; i++) cw[i] = d[i];
        for (int j = 0; j < 8; j++) cw[7+j] = p[7-j];
        return cw ^ m;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [6:0] d, input logic [14:0] m, input logic [14:0] exp);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        check("in_ready_wait", 32'(in_ready), 32'd1);
        data_in  = d;
        err_mask = m;
        in_valid = 1'b1;
        exp_q.push_back(exp);
        step();
        in_valid = 1'b0;
        check("busy_after_accept", 32'(busy), 32'd1);
    endtask

    task automatic collect(input logic [14:0] m, input int hold);
        int lat;
        logic [14:0] exp;
        lat = 0;
        while (!out_valid && lat < 50) begin
            step();
            lat++;
        end
        check("latency", 32'(lat), 32'd7);
        check("in_ready_done", 32'(in_ready), 32'd0);
        check("busy_done", 32'(busy), 32'd0);
        exp = 15'h0000;
        if (exp_q.size() > 0) exp = exp_q.pop_front();
        check("codeword", 32'(codeword), 32'(exp));
        check("remainder", 32'(rem_of(codeword ^ m)), 32'd0);
        for (int h = 0; h < hold; h++) begin
            step();
            check("hold_codeword", 32'(codeword), 32'(exp));
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("valid_drop", 32'(out_valid), 32'd0);
        check("in_ready_back", 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        data_in   = 7'h00;
        err_mask  = 15'h0000;
        out_ready = 1'b0;
        repeat (3) step();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_codeword", 32'(codeword), 32'd0);
        rst_n = 1'b1;
        step();

        // Known vectors and linearity.
        accept(7'h01, 15'h0000, 15'h0B81); collect(15'h0000, 0);
        accept(7'h02, 15'h0000, 15'h1702); collect(15'h0000, 0);
        accept(7'h00, 15'h0000, 15'h0000); collect(15'h0000, 0);
        accept(7'h7F, 15'h0000, 15'h7FFF); collect(15'h0000, 0);
        accept(7'h03, 15'h0000, 15'h1C83); collect(15'h0000, 0);

        // Error injection.
        accept(7'h01, 15'h0001, 15'h0B80); collect(15'h0001, 0);
        accept(7'h01, 15'h4001, 15'h4B80); collect(15'h4001, 0);

        // Backpressure with a competing message held on the input.
        accept(7'h01, 15'h0000, 15'h0B81);
        data_in  = 7'h55;
        err_mask = 15'h0000;
        in_valid = 1'b1;
        collect(15'h0000, 20);
        check("no_accept_with_out_ready", 32'(busy), 32'd0);
        exp_q.push_back(enc_model(7'h55, 15'h0000));
        step();
        in_valid = 1'b0;
        check("accept_next_cycle", 32'(busy), 32'd1);
        collect(15'h0000, 2);

        // Reset in the 4th shift cycle discards the word.
        accept(7'h7F, 15'h1234, 15'h0000);
        exp_q.delete();
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_codeword", 32'(codeword), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (10) step();
        check("abort_no_emit", 32'(out_valid), 32'd0);
        accept(7'h02, 15'h0000, 15'h1702); collect(15'h0000, 0);

        // All messages, with random masks on odd messages.
        for (int d = 0; d < 128; d++) begin
            logic [14:0] m;
            m = (d % 2 == 1) ? 15'($urandom_range(0, 32767)) : 15'h0000;
            accept(7'(d), m, enc_model(7'(d), m));
            collect(m, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
